mc_circ_queue: RTL and testbench

Multi-channel, pointer-based successor to the shift-register queue. It holds NUM_CH independent FIFOs of DEPTH entries each, with a single shared push port steered by a channel index and one pop per channel. Each channel reports its occupancy, almost-full and an optional same-cycle fall-through path. It sits between the command scheduler and the per-bank or per-channel datapaths, where write data and read returns are buffered per DRAM channel.

---
 rtl/mc_queue_pkg.sv | 17 +
 rtl/mc_circ_queue_ch.sv | 51 +++++
 rtl/mc_circ_queue.sv | 52 +++++
 tb/tb_mc_circ_queue.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mc_queue_pkg.sv
// mc_queue_pkg: width helpers and per-channel status type shared by the multi-channel queue.
package mc_queue_pkg;
  localparam int MAX_CW = 16;
  function automatic int chw(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction
  function automatic int cw(input int depth);
    return $clog2(depth) + 1;
  endfunction
  typedef struct packed {
    logic              out_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [MAX_CW-1:0] count;
  } ch_status_t;
endpackage

// File: rtl/mc_circ_queue_ch.sv
// circ_queue_ch: one pointer-based FIFO channel with wrap-bit pointers and optional fall-through.
module circ_queue_ch
  import mc_queue_pkg::*;
#(
  parameter int WIDTH        = 1024,
  parameter int DEPTH        = 4,
  parameter int FALL_THROUGH = 0,
  parameter int AFULL_THRESH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output ch_status_t       st,
  output logic             err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [CW-1:0]    r_wr, r_rd;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    w_cnt;
  logic             w_full, w_empty, w_byp, w_valid, w_push_ok, w_pop_ok;
  always_comb begin
    w_cnt     = r_wr - r_rd;
    w_full    = w_cnt == CW'(DEPTH);
    w_empty   = w_cnt == '0;
    w_byp     = (FALL_THROUGH != 0) && w_empty && push;
    w_valid   = !w_empty || w_byp;
    w_pop_ok  = pop && w_valid;
    // a bypassed entry that is popped in the same cycle never touches storage
    w_push_ok = push && !w_full && !(w_byp && pop);
    err       = (push && w_full) || (pop && !w_valid);
    data_out  = w_byp ? data_in : r_mem[r_rd[AW-1:0]];
    st        = '{out_valid: w_valid, full: w_full, empty: w_empty,
                  almost_full: w_cnt >= CW'(AFULL_THRESH), count: MAX_CW'(w_cnt)};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      r_wr <= r_wr + CW'(w_push_ok);
      r_rd <= r_rd + CW'(w_pop_ok && !w_empty);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr[AW-1:0]] <= data_in;
  end
endmodule

// File: rtl/mc_circ_queue.sv
// mc_circ_queue: NUM_CH independent FIFOs behind one steered push port, with a sticky error flag.
module mc_circ_queue
  import mc_queue_pkg::*;
#(
  parameter int WIDTH        = 1024,
  parameter int DEPTH        = 4,
  parameter int NUM_CH       = 4,
  parameter int FALL_THROUGH = 0,
  parameter int AFULL_THRESH = 3,
  localparam int CHW         = chw(NUM_CH),
  localparam int CW          = cw(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [CHW-1:0]          push_ch,
  input  logic [WIDTH-1:0]        data_in,
  input  logic [NUM_CH-1:0]       pop,
  output logic [NUM_CH-1:0]       out_valid,
  output logic [NUM_CH*WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       empty,
  output logic [NUM_CH-1:0]       almost_full,
  output logic [NUM_CH*CW-1:0]    count,
  output logic                    error_flag
);
  logic [NUM_CH-1:0] w_err;
  logic              w_bad_ch;
  logic              r_err;
  assign w_bad_ch   = push && (32'(push_ch) >= NUM_CH);
  assign error_flag = r_err;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_status_t w_st;
    logic       w_unused;
    circ_queue_ch #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .FALL_THROUGH(FALL_THROUGH), .AFULL_THRESH(AFULL_THRESH)
    ) u_ch (
      .clk(clk), .rst(rst), .push(push && push_ch == CHW'(c)), .data_in(data_in),
      .pop(pop[c]), .data_out(data_out[c*WIDTH +: WIDTH]), .st(w_st), .err(w_err[c])
    );
    assign out_valid[c]        = w_st.out_valid;
    assign full[c]             = w_st.full;
    assign empty[c]            = w_st.empty;
    assign almost_full[c]      = w_st.almost_full;
    assign count[c*CW +: CW]   = w_st.count[CW-1:0];
    assign w_unused            = ^w_st.count;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= r_err || (|w_err) || w_bad_ch;
  end
endmodule

// File: tb/tb_mc_circ_queue.sv
// tb_mc_circ_queue: directed scenarios with a pop-data scoreboard checked by an independent monitor.
module tb_mc_circ_queue;
  localparam int W = 16;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic [1:0]    push_ch = '0;
  logic [W-1:0]  data_in = '0;
  logic [3:0]    pop = '0;
  logic [3:0]    ov0, full0, empty0, af0, ov1, full1, empty1, af1;
  logic [4*W-1:0] do0, do1;
  logic [11:0]   cnt0, cnt1;
  logic          err0, err1;
  int            checks = 0;
  int            errors = 0;
  logic [17:0]   exp_q[$];

  always #5 clk = ~clk;

  mc_circ_queue #(.WIDTH(W), .DEPTH(4), .NUM_CH(4), .FALL_THROUGH(0), .AFULL_THRESH(3)) u0 (
    .clk(clk), .rst(rst), .push(push), .push_ch(push_ch), .data_in(data_in), .pop(pop),
    .out_valid(ov0), .data_out(do0), .full(full0), .empty(empty0), .almost_full(af0),
    .count(cnt0), .error_flag(err0));
  mc_circ_queue #(.WIDTH(W), .DEPTH(4), .NUM_CH(4), .FALL_THROUGH(1), .AFULL_THRESH(3)) u1 (
    .clk(clk), .rst(rst), .push(push), .push_ch(push_ch), .data_in(data_in), .pop(pop),
    .out_valid(ov1), .data_out(do1), .full(full1), .empty(empty1), .almost_full(af1),
    .count(cnt1), .error_flag(err1));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic cyc(input logic p, input logic [1:0] ch, input logic [W-1:0] d, input logic [3:0] pp);
    push = p; push_ch = ch; data_in = d; pop = pp;
    @(posedge clk); #1;
    push = 1'b0; pop = '0;
  endtask

  task automatic expect_pop(input logic [1:0] ch, input logic [W-1:0] d);
    exp_q.push_back({ch, d});
  endtask

  function automatic logic [2:0] c0(input int ch);
    return cnt0[ch*3 +: 3];
  endfunction

  // every accepted pop on the FALL_THROUGH=0 instance must match the next expected entry
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < 4; c++) begin
        if (pop[c] && ov0[c]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop ch%0d: got %0h expected none", c, do0[c*W +: W]);
          end else begin
            logic [17:0] e;
            e = exp_q.pop_front();
            chk($sformatf("pop_ch%0d", c), {30'(c), do0[c*W +: W]} & 32'h3_FFFF, {14'd0, e});
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;
    chk("rst_count", 32'(cnt0), 0);
    chk("rst_empty", 32'(empty0), 32'hF);
    chk("rst_valid", 32'(ov0), 0);
    chk("rst_full_af", 32'({full0, af0}), 0);
    chk("rst_err", 32'(err0), 0);
    rst = 1'b0;
    // fill ch2
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 2'd2, W'(16'hA0 + i), 4'b0);
      chk($sformatf("fill_count%0d", i), 32'(c0(2)), i + 1);
      chk($sformatf("fill_af%0d", i), 32'(af0[2]), (i >= 2) ? 1 : 0);
    end
    chk("fill_full", 32'(full0[2]), 1);
    chk("fill_err_pre", 32'(err0), 0);
    cyc(1'b1, 2'd2, 16'hA4, 4'b0);
    chk("over_count", 32'(c0(2)), 4);
    chk("over_err", 32'(err0), 1);
    // drain ch2
    for (int i = 0; i < 4; i++) expect_pop(2'd2, W'(16'hA0 + i));
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'd0, '0, 4'b0100);
    chk("drain_empty", 32'(empty0[2]), 1);
    chk("drain_valid", 32'(ov0[2]), 0);
    cyc(1'b0, 2'd0, '0, 4'b0100);
    chk("under_err", 32'(err0), 1);
    chk("under_count", 32'(c0(2)), 0);
    // wrap on ch0
    do_reset();
    for (int i = 1; i <= 3; i++) cyc(1'b1, 2'd0, W'(i), 4'b0);
    expect_pop(2'd0, 16'd1);
    expect_pop(2'd0, 16'd2);
    cyc(1'b0, 2'd0, '0, 4'b0001);
    cyc(1'b0, 2'd0, '0, 4'b0001);
    for (int i = 4; i <= 6; i++) cyc(1'b1, 2'd0, W'(i), 4'b0);
    chk("wrap_count", 32'(c0(0)), 4);
    chk("wrap_full", 32'(full0[0]), 1);
    for (int i = 3; i <= 6; i++) expect_pop(2'd0, W'(i));
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'd0, '0, 4'b0001);
    chk("wrap_empty", 32'(empty0[0]), 1);
    chk("wrap_err", 32'(err0), 0);
    // simultaneous push/pop on ch1
    do_reset();
    cyc(1'b1, 2'd1, 16'h21, 4'b0);
    cyc(1'b1, 2'd1, 16'h22, 4'b0);
    expect_pop(2'd1, 16'h21);
    cyc(1'b1, 2'd1, 16'h23, 4'b0010);
    chk("pp_count", 32'(c0(1)), 2);
    chk("pp_err", 32'(err0), 0);
    cyc(1'b1, 2'd1, 16'h24, 4'b0);
    cyc(1'b1, 2'd1, 16'h25, 4'b0);
    chk("pp_full", 32'(full0[1]), 1);
    expect_pop(2'd1, 16'h22);
    cyc(1'b1, 2'd1, 16'h26, 4'b0010);
    chk("ppfull_count", 32'(c0(1)), 3);
    chk("ppfull_err", 32'(err0), 1);
    for (int i = 3; i <= 5; i++) expect_pop(2'd1, W'(16'h20 + i));
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'd0, '0, 4'b0010);
    chk("pp_empty", 32'(empty0[1]), 1);
    // fall-through on u1
    do_reset();
    push = 1'b1; push_ch = 2'd3; data_in = 16'hBEEF; pop = 4'b1000;
    #2;
    chk("ft_valid", 32'(ov1[3]), 1);
    chk("ft_data", 32'(do1[3*W +: W]), 32'hBEEF);
    chk("noft_valid", 32'(ov0[3]), 0);
    @(posedge clk); #1;
    push = 1'b0; pop = '0;
    chk("ft_count", 32'(cnt1[9 +: 3]), 0);
    chk("ft_empty", 32'(empty1[3]), 1);
    chk("ft_err", 32'(err1), 0);
    chk("noft_count", 32'(c0(3)), 1);
    push = 1'b1; push_ch = 2'd2; data_in = 16'h55;
    #2;
    chk("ft_nopop_valid", 32'(ov1[2]), 1);
    chk("ft_nopop_data", 32'(do1[2*W +: W]), 32'h55);
    @(posedge clk); #1;
    push = 1'b0;
    chk("ft_nopop_count", 32'(cnt1[6 +: 3]), 1);
    expect_pop(2'd2, 16'h55);
    cyc(1'b0, 2'd0, '0, 4'b0100);
    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'd0, W'(16'h70 + i), 4'b0);
    cyc(1'b1, 2'd1, 16'h80, 4'b0);
    chk("pre_rst_count", 32'(cnt0[5:0]), 32'h0B);
    #2;
    rst = 1'b1;
    #1;
    chk("async_count", 32'(cnt0), 0);
    chk("async_valid", 32'(ov0), 0);
    chk("async_full", 32'(full0), 0);
    chk("async_empty", 32'(empty0), 32'hF);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1'b1, 2'd0, 16'h11, 4'b0);
    expect_pop(2'd0, 16'h11);
    cyc(1'b0, 2'd0, '0, 4'b0001);
    chk("post_rst_count", 32'(c0(0)), 0);
    @(posedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
